// File: rtl/if_stage_ib_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, defaults,
// request FSM encoding and PC increment helper.
package if_stage_ib_pkg;

  localparam int          BR_BUS_WD        = 33;
  localparam int          FS_TO_DS_BUS_WD  = 64;
  localparam int          IB_DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_WAIT = 1'b1
  } req_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_ib_if_inst_buf.sv
// if_inst_buf: in-order instruction buffer. Entries are allocated at request
// acceptance (pc known, inst pending), filled in order by responses, and
// popped from the head. Flush clears every entry and pointer.
module if_inst_buf
  import if_stage_ib_pkg::*;
#(
  parameter int IB_DEPTH = IB_DEPTH_DEFAULT,
  localparam int PW = $clog2(IB_DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          alloc_en,
  input  logic [31:0]   alloc_pc,
  input  logic          fill_en,
  input  logic [31:0]   fill_inst,
  input  logic          pop_en,
  output logic          head_filled,
  output logic          head_is_fill,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst,
  output logic [PW:0]   count,
  output logic [PW:0]   unfilled
);

  logic [31:0]         pc_q   [IB_DEPTH];
  logic [31:0]         inst_q [IB_DEPTH];
  logic [IB_DEPTH-1:0] filled_q;
  logic [PW:0]         alloc_ptr;
  logic [PW:0]         fill_ptr;
  logic [PW:0]         head_ptr;
  logic [PW:0]         count_q;

  // Entry storage: allocation clears filled, a response sets it.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      filled_q <= '0;
    end else begin
      if (alloc_en) begin
        pc_q[alloc_ptr[PW-1:0]]     <= alloc_pc;
        filled_q[alloc_ptr[PW-1:0]] <= 1'b0;
      end
      if (fill_en) begin
        inst_q[fill_ptr[PW-1:0]]    <= fill_inst;
        filled_q[fill_ptr[PW-1:0]]  <= 1'b1;
      end
    end
  end

  // Pointers and occupancy; flush takes priority over any same-cycle update.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count_q   <= '0;
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + 1'b1;
      if (fill_en)  fill_ptr  <= fill_ptr + 1'b1;
      if (pop_en)   head_ptr  <= head_ptr + 1'b1;
      count_q <= count_q + (PW+1)'(alloc_en) - (PW+1)'(pop_en);
    end
  end

  // Head view and bookkeeping for the parent's credit/discard logic.
  always_comb begin
    head_filled  = (count_q != '0) && filled_q[head_ptr[PW-1:0]];
    head_is_fill = (count_q != '0) && (head_ptr == fill_ptr);
    head_pc      = pc_q[head_ptr[PW-1:0]];
    head_inst    = inst_q[head_ptr[PW-1:0]];
    count        = count_q;
    unfilled     = alloc_ptr - fill_ptr;
  end

endmodule

// File: rtl/if_stage_ib.sv
// if_stage_ib: instruction-fetch stage with multiple outstanding SRAM-like
// requests and an in-order instruction buffer. Branch flush discards
// in-flight responses via discard_cnt.
// Optional macro IF_RDATA_BYPASS_EN: present rdata to ID in the same cycle it
// fills an empty-head buffer.
module if_stage_ib
  import if_stage_ib_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IB_DEPTH = IB_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ds_allowin,
  input  logic [BR_BUS_WD-1:0]        br_bus,
  output logic                        fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
  output logic                        inst_sram_req,
  output logic                        inst_sram_wr,
  output logic [1:0]                  inst_sram_size,
  output logic [3:0]                  inst_sram_wstrb,
  output logic [31:0]                 inst_sram_addr,
  output logic [31:0]                 inst_sram_wdata,
  input  logic                        inst_sram_addr_ok,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata
);

  localparam int PW = $clog2(IB_DEPTH);
  localparam int OW = PW + 2;
  localparam logic [OW-1:0] DEPTH_W = OW'(IB_DEPTH);
`ifdef IF_RDATA_BYPASS_EN
  localparam bit RDATA_BYPASS = 1'b1;
`else
  localparam bit RDATA_BYPASS = 1'b0;
`endif

  req_state_e  state_q, state_d;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_addr_q;
  logic        req_stale_q;
  logic [PW:0] discard_q;

  logic        br_taken;
  logic [31:0] br_target;
  logic        accept, acc_drop, acc_alloc;
  logic        fill, drop, pop, bypass_hit;
  logic        load;
  logic [31:0] load_addr;
  logic [OW-1:0] disc_nx, count_nx, occ_now, occ_after;

  logic        head_filled, head_is_fill;
  logic [31:0] head_pc, head_inst;
  logic [PW:0] ib_count, ib_unfilled;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // Handshake decode: accepted requests are either kept or marked for discard.
  always_comb begin
    accept     = (state_q == REQ_WAIT) && inst_sram_addr_ok;
    acc_drop   = accept && (req_stale_q || br_taken);
    acc_alloc  = accept && !req_stale_q && !br_taken;
    drop       = inst_sram_data_ok && (discard_q != '0);
    fill       = inst_sram_data_ok && (discard_q == '0);
    bypass_hit = RDATA_BYPASS && fill && head_is_fill;
    fs_to_ds_valid = (head_filled || bypass_hit) && !br_taken;
    pop        = fs_to_ds_valid && ds_allowin;
  end

  // Credit: a flush converts unfilled entries (minus one filled this cycle)
  // into pending discards, so occupancy after the flush still bounds memory.
  always_comb begin
    disc_nx = OW'(discard_q) - OW'(drop) + OW'(acc_drop);
    if (br_taken) disc_nx = disc_nx + OW'(ib_unfilled) - OW'(fill);
    count_nx  = br_taken ? '0 : OW'(ib_count) + OW'(acc_alloc) - OW'(pop);
    occ_now   = OW'(ib_count) + OW'(discard_q) + OW'(state_q == REQ_WAIT);
    occ_after = count_nx + disc_nx;
    if (state_q == REQ_IDLE) load = (occ_now < DEPTH_W);
    else                     load = accept && (occ_after < DEPTH_W);
    load_addr = br_taken ? br_target : fetch_pc_q;
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= REQ_IDLE;
    else         state_q <= state_d;
  end

  // Request FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ_IDLE: if (load)            state_d = REQ_WAIT;
      REQ_WAIT: if (accept && !load) state_d = REQ_IDLE;
      default:                       state_d = REQ_IDLE;
    endcase
  end

  // Fetch PC, request address, stale flag and discard counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= '0;
      req_stale_q <= 1'b0;
      discard_q   <= '0;
    end else begin
      discard_q <= disc_nx[PW:0];
      if (load) begin
        req_addr_q <= load_addr;
        fetch_pc_q <= next_pc(load_addr);
      end else if (br_taken) begin
        fetch_pc_q <= br_target;
      end
      if (accept)                              req_stale_q <= 1'b0;
      else if (state_q == REQ_WAIT && br_taken) req_stale_q <= 1'b1;
    end
  end

  // Output decode for memory and ID.
  always_comb begin
    inst_sram_req   = (state_q == REQ_WAIT);
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'b10;
    inst_sram_wstrb = '0;
    inst_sram_addr  = req_addr_q;
    inst_sram_wdata = '0;
    fs_to_ds_bus    = {(bypass_hit ? inst_sram_rdata : head_inst), head_pc};
  end

  if_inst_buf #(
    .IB_DEPTH (IB_DEPTH)
  ) u_ib (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (br_taken),
    .alloc_en     (acc_alloc),
    .alloc_pc     (req_addr_q),
    .fill_en      (fill),
    .fill_inst    (inst_sram_rdata),
    .pop_en       (pop),
    .head_filled  (head_filled),
    .head_is_fill (head_is_fill),
    .head_pc      (head_pc),
    .head_inst    (head_inst),
    .count        (ib_count),
    .unfilled     (ib_unfilled)
  );

endmodule
